// File: rtl/uart_value_tx_pkg.sv
// Shared definitions for the UART value-reply path.
//   ASCII_CR / ASCII_LF : line terminator bytes
//   SEQ_*               : reply sequencer state encodings
//   BYTE_*              : byte serializer state encodings
//   baud_div()          : clocks per bit, integer-truncated
//   nib_to_ascii()      : 4-bit nibble to uppercase ASCII hex digit
package uart_value_tx_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam logic [1:0] SEQ_IDLE = 2'd0;
  localparam logic [1:0] SEQ_LOAD = 2'd1;
  localparam logic [1:0] SEQ_SEND = 2'd2;

  localparam logic [1:0] BYTE_IDLE  = 2'd0;
  localparam logic [1:0] BYTE_START = 2'd1;
  localparam logic [1:0] BYTE_DATA  = 2'd2;
  localparam logic [1:0] BYTE_STOP  = 2'd3;

  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/uart_value_tx_if.sv
// Request/serial bundle of the value-reply block.
//   start : single-cycle request        (master -> slave)
//   value : 16-bit value to report      (master -> slave)
//   tx    : UART line, idle high        (slave -> master)
//   busy  : transfer in progress        (slave -> master)
//   done  : one-cycle end-of-transfer   (slave -> master)
interface uart_value_tx_if;
  logic        start;
  logic [15:0] value;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (output start, output value, input tx, input busy, input done);
  modport slave  (input start, input value, output tx, output busy, output done);
endinterface

// File: rtl/uart_value_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit.
//   clk, rst  : clock, asynchronous active-high reset
//   tx_start  : accepted only while idle
//   tx_data   : byte to send, captured on acceptance
//   tx        : registered serial line, idle high
//   tx_busy   : high while a frame is in flight
//   tx_done   : one-cycle pulse in the final clock of the stop bit
//
// state      | meaning
// BYTE_IDLE  | line high, waiting for tx_start
// BYTE_START | driving start bit (0)
// BYTE_DATA  | driving data bits 0..7
// BYTE_STOP  | driving stop bit (1)
module uart_tx_byte
  import uart_value_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BYTE_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        BYTE_IDLE: begin
          if (tx_start) begin
            r_shift <= tx_data;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b0;
            r_state <= BYTE_START;
          end
        end
        BYTE_START: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_tx    <= r_shift[0];
            r_state <= BYTE_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        BYTE_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= BYTE_STOP;
            end else begin
              // shift keeps the next bit at position 1 so the line is fed straight from a flop
              r_bit   <= r_bit + 3'd1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        BYTE_STOP: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_state <= BYTE_IDLE;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= BYTE_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx      = r_tx;
  assign tx_busy = (r_state != BYTE_IDLE);
  // asserted in the last stop clock so the sequencer can reload with a 2-clock gap
  assign tx_done = (r_state == BYTE_STOP) && w_bit_end;

endmodule

// File: rtl/uart_value_tx.sv
// Reply path: renders a 16-bit value as 4 ASCII hex digits (MS nibble
// first), optionally followed by CR LF, and sends them as 8N1 frames.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : start/value in, tx/busy/done out (uart_value_tx_if.slave)
//
// state    | meaning
// SEQ_IDLE | waiting for start; value latched on acceptance
// SEQ_LOAD | byte for idx selected, tx_start issued on exit
// SEQ_SEND | waiting for the serializer to finish the byte
module uart_value_tx
  import uart_value_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned SEND_CRLF = 1
) (
  input  logic     clk,
  input  logic     rst,
  uart_value_tx_if.slave bus
);
  localparam logic [2:0] IDX_LAST = (SEND_CRLF != 0) ? 3'd5 : 3'd3;

  logic [1:0]  r_state;
  logic [15:0] r_val;
  logic [2:0]  r_idx;
  logic        r_busy;
  logic        r_tx_start;
  logic [7:0]  w_byte;
  logic        w_last;
  logic        w_tx;
  logic        w_tx_busy;
  logic        w_tx_done;

  always_comb begin
    w_byte = ASCII_LF;
    case (r_idx)
      3'd0:    w_byte = nib_to_ascii(r_val[15:12]);
      3'd1:    w_byte = nib_to_ascii(r_val[11:8]);
      3'd2:    w_byte = nib_to_ascii(r_val[7:4]);
      3'd3:    w_byte = nib_to_ascii(r_val[3:0]);
      3'd4:    w_byte = ASCII_CR;
      default: w_byte = ASCII_LF;
    endcase
  end

  assign w_last = (r_idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= SEQ_IDLE;
      r_val      <= '0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        SEQ_IDLE: begin
          if (bus.start) begin
            r_val   <= bus.value;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= SEQ_LOAD;
          end
        end
        SEQ_LOAD: begin
          if (!w_tx_busy) begin
            r_tx_start <= 1'b1;
            r_state    <= SEQ_SEND;
          end
        end
        SEQ_SEND: begin
          if (w_tx_done) begin
            if (w_last) begin
              r_busy  <= 1'b0;
              r_state <= SEQ_IDLE;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= SEQ_LOAD;
            end
          end
        end
        default: r_state <= SEQ_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_tx_byte (
    .clk      (clk),
    .rst      (rst),
    .tx_start (r_tx_start),
    .tx_data  (w_byte),
    .tx       (w_tx),
    .tx_busy  (w_tx_busy),
    .tx_done  (w_tx_done)
  );

  assign bus.tx   = w_tx;
  assign bus.busy = r_busy;
  // done shares the final stop clock; the FSM is still in SEND, so a start here is not taken
  assign bus.done = (r_state == SEQ_SEND) && w_tx_done && w_last;

endmodule

// File: tb/tb_uart_value_tx.sv
module tb_uart_value_tx;
  localparam int unsigned CLK_FREQ = 175_000;
  localparam int unsigned BAUD     = 10_000;
  localparam int DIV   = CLK_FREQ / BAUD;   // 17, truncated from 17.5
  localparam int FRAME = 10 * DIV;
  localparam int SLOT  = FRAME + 2;
  localparam int TAIL  = 12 * DIV;
  localparam int NLOG  = 32768;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  uart_value_tx_if if_a();
  uart_value_tx_if if_b();

  uart_value_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .SEND_CRLF(1)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a));
  uart_value_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .SEND_CRLF(0)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic lg_tx   [2][NLOG];
  logic lg_busy [2][NLOG];
  logic lg_done [2][NLOG];

  always @(negedge clk) begin
    if (cyc < NLOG) begin
      lg_tx[0][cyc]   = if_a.tx;
      lg_busy[0][cyc] = if_a.busy;
      lg_done[0][cyc] = if_a.done;
      lg_tx[1][cyc]   = if_b.tx;
      lg_busy[1][cyc] = if_b.busy;
      lg_done[1][cyc] = if_b.done;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // reference: byte string from the value, then line level from frame arithmetic
  logic [7:0] exp_q[$];

  function automatic logic [7:0] hex_char(input int d);
    return (d < 10) ? 8'(48 + d) : 8'(55 + d);
  endfunction

  task automatic build_exp(input logic [15:0] v, input bit crlf);
    exp_q.delete();
    for (int n = 3; n >= 0; n--) exp_q.push_back(hex_char(int'(v[4*n +: 4])));
    if (crlf) begin
      exp_q.push_back(8'd13);
      exp_q.push_back(8'd10);
    end
  endtask

  function automatic logic exp_line(input int i, input int f0);
    int r, k, off, j;
    logic [7:0] b;
    if (i < f0) return 1'b1;
    r = i - f0; k = r / SLOT; off = r % SLOT;
    if (k >= exp_q.size() || off >= FRAME) return 1'b1;
    j = off / DIV;
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    b = exp_q[k];
    return b[j-1];
  endfunction

  logic [7:0] rx_q[$];
  int         rx_t[$];

  task automatic decode(input int d, input int from, input int upto);
    int i;
    logic [7:0] b;
    rx_q.delete(); rx_t.delete();
    i = from;
    while (i <= upto && i + FRAME < NLOG) begin
      if (lg_tx[d][i] == 1'b0 && lg_tx[d][i-1] == 1'b1) begin
        for (int k = 0; k < 8; k++) b[k] = lg_tx[d][i + (k+1)*DIV + DIV/2];
        rx_q.push_back(b); rx_t.push_back(i);
        i += FRAME;
      end else begin
        i++;
      end
    end
  endtask

  task automatic check_xfer(input int d, input int s, input logic [15:0] v,
                            input int tail, input string tag);
    int f0, last_end, hi, bad_tx, bad_busy, bad_done, t0;
    logic [31:0] got;
    build_exp(v, d == 0);
    f0 = s + 2;
    last_end = f0 + (exp_q.size() - 1) * SLOT + FRAME;
    hi = last_end + tail;
    if (hi >= NLOG - 2) hi = NLOG - 3;
    while (cyc <= hi + 1) @(negedge clk);
    bad_tx = 0; bad_busy = 0; bad_done = 0;
    for (int i = s - 1; i <= hi; i++) begin
      if (lg_tx[d][i] !== exp_line(i, f0)) bad_tx++;
      if (lg_busy[d][i] !== (i >= s && i < last_end)) bad_busy++;
      if (lg_done[d][i] !== (i == last_end - 1)) bad_done++;
    end
    chk({tag, ":tx_wave_bad_cycles"}, 32'(bad_tx), 32'd0);
    chk({tag, ":busy_bad_cycles"}, 32'(bad_busy), 32'd0);
    chk({tag, ":done_bad_cycles"}, 32'(bad_done), 32'd0);
    decode(d, s - 1, hi);
    chk({tag, ":frame_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    t0 = (rx_t.size() > 0) ? rx_t[0] : -1;
    chk({tag, ":first_start_cycle"}, 32'(t0), 32'(f0));
    for (int k = 0; k < exp_q.size(); k++) begin
      got = (k < rx_q.size()) ? 32'(rx_q[k]) : 32'hFFFF_FFFF;
      chk($sformatf("%s:byte%0d", tag, k), got, 32'(exp_q[k]));
    end
  endtask

  task automatic drive(input int d, input logic st, input logic [15:0] v);
    if (d == 0) begin
      if_a.start = st; if_a.value = v;
    end else begin
      if_b.start = st; if_b.value = v;
    end
  endtask

  task automatic pulse(input int d, input logic [15:0] v, output int s);
    @(negedge clk);
    drive(d, 1'b1, v);
    s = cyc + 1;
    @(negedge clk);
    drive(d, 1'b0, v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s2, t, bad, waited;
    logic [15:0] v, v2;
    drive(0, 1'b0, 16'h0);
    drive(1, 1'b0, 16'h0);
    repeat (3) @(negedge clk);
    chk("rst:a_tx",   32'(if_a.tx),   32'd1);
    chk("rst:a_busy", 32'(if_a.busy), 32'd0);
    chk("rst:a_done", 32'(if_a.done), 32'd0);
    chk("rst:b_tx",   32'(if_b.tx),   32'd1);
    chk("rst:b_busy", 32'(if_b.busy), 32'd0);
    chk("rst:b_done", 32'(if_b.done), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    pulse(0, 16'h0342, s); check_xfer(0, s, 16'h0342, TAIL, "v0342");
    pulse(0, 16'hABCF, s); check_xfer(0, s, 16'hABCF, TAIL, "vABCF");

    // value change and a second start while busy must not disturb the transfer
    pulse(0, 16'h1234, s);
    while (cyc < s + 2 + SLOT + 3 * DIV) @(negedge clk);
    drive(0, 1'b0, 16'hFFFF);
    @(negedge clk); drive(0, 1'b1, 16'hFFFF);
    @(negedge clk); drive(0, 1'b0, 16'hFFFF);
    check_xfer(0, s, 16'h1234, TAIL, "latch1234");

    for (int n = 0; n < 3; n++) begin
      v = 16'($urandom);
      pulse(0, v, s);
      check_xfer(0, s, v, TAIL, $sformatf("rnd_a%0d_%04h", n, v));
    end

    // reset during the start bit of the second byte
    v = 16'($urandom);
    pulse(0, v, s);
    while (cyc < s + 2 + SLOT + DIV / 2) @(negedge clk);
    chk("rst_mid:pre_tx",   32'(if_a.tx),   32'd0);
    chk("rst_mid:pre_busy", 32'(if_a.busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid:tx",   32'(if_a.tx),   32'd1);
    chk("rst_mid:busy", 32'(if_a.busy), 32'd0);
    chk("rst_mid:done", 32'(if_a.done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    t = cyc;
    while (cyc <= t + TAIL + 1) @(negedge clk);
    bad = 0;
    for (int i = t; i <= t + TAIL; i++)
      if (lg_tx[0][i] !== 1'b1 || lg_busy[0][i] !== 1'b0 || lg_done[0][i] !== 1'b0) bad++;
    chk("rst_mid:quiet_bad_cycles", 32'(bad), 32'd0);
    pulse(0, 16'h0009, s); check_xfer(0, s, 16'h0009, TAIL, "v0009_after_rst");

    // back-to-back: start in the done cycle is dropped, the next cycle is taken
    v = 16'($urandom);
    pulse(0, v, s);
    waited = 0;
    while (if_a.done !== 1'b1 && waited < 8 * SLOT) begin
      @(negedge clk);
      waited++;
    end
    chk("b2b:done_seen", 32'(if_a.done), 32'd1);
    v2 = 16'($urandom);
    drive(0, 1'b1, ~v2);
    @(negedge clk); drive(0, 1'b1, v2); s2 = cyc + 1;
    @(negedge clk); drive(0, 1'b0, v2);
    check_xfer(0, s, v, 0, "b2b_first");
    check_xfer(0, s2, v2, TAIL, "b2b_second");

    pulse(1, 16'h0000, s); check_xfer(1, s, 16'h0000, TAIL, "nocrlf_0000");
    for (int n = 0; n < 2; n++) begin
      v = 16'($urandom);
      pulse(1, v, s);
      check_xfer(1, s, v, TAIL, $sformatf("rnd_b%0d_%04h", n, v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
